// File: rtl/ram_boot_loader_pkg.sv
// Shared definitions for the RAM boot loader: default bus widths, loader
// state encoding and a small state classification helper.
package ram_boot_loader_pkg;

  localparam int DEF_DATALINES = 16;
  localparam int DEF_ADLINES   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // States during which the loader reports itself as busy.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_LOAD) || (s == ST_VERIFY);
  endfunction

endpackage

// File: rtl/ram_boot_loader_if.sv
// Word stream plus RAM bus seen by the boot loader. The loader is the
// master: it drives in_ready and the RAM strobes/address/data, and
// receives the stream word and the combinational RAM read data.
interface ram_boot_loader_if
  import ram_boot_loader_pkg::*;
#(
  parameter int DATALINES = DEF_DATALINES,
  parameter int ADLINES   = DEF_ADLINES
);

  logic [DATALINES-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ADLINES-1:0]   addressbus;
  logic [DATALINES-1:0] toram;
  logic [DATALINES-1:0] fromram;
  logic                 read;
  logic                 write;

  modport master (
    input  in_data, in_valid, fromram,
    output in_ready, addressbus, toram, read, write
  );

  modport slave (
    output in_data, in_valid, fromram,
    input  in_ready, addressbus, toram, read, write
  );

endinterface

// File: rtl/ram_addr_seq.sv
// Address sequencer shared by the load and verify passes: holds the base
// address and word count, steps an index, and produces the modular RAM
// address (wrapping at 2^ADLINES) together with a terminal-count flag.
module ram_addr_seq #(
  parameter int ADLINES = 8,
  parameter int CNTW    = ADLINES + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic [ADLINES-1:0] base_in,
  input  logic [CNTW-1:0]    count_in,
  input  logic               clr,
  input  logic               inc,
  output logic [ADLINES-1:0] addr,
  output logic [ADLINES-1:0] addr_next,
  output logic               last
);

  logic [ADLINES-1:0] base_q;
  logic [CNTW-1:0]    count_q;
  logic [CNTW-1:0]    idx_q;

  // Capture base/count on a new load; index restarts on init or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else if (init) begin
      base_q  <= base_in;
      count_q <= count_in;
      idx_q   <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + CNTW'(1);
    end
  end

  // Only the low index bits reach the address, so images longer than the
  // RAM wrap around and overwrite from base.
  assign addr      = base_q + idx_q[ADLINES-1:0];
  assign addr_next = addr + ADLINES'(1);
  assign last      = (idx_q == count_q - CNTW'(1));

endmodule

// File: rtl/ram_boot_loader.sv
// Program loader: streams words into RAM from a programmable base, can
// read the image back and compare checksums, then enables the CU. Owns
// the RAM bus in every state except RUN.
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int DATALINES = DEF_DATALINES,
  parameter int ADLINES   = DEF_ADLINES,
  parameter int CNTW      = ADLINES + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [ADLINES-1:0] load_base,
  input  logic [CNTW-1:0]    load_count,
  input  logic               verify_en,
  input  logic               halt,
  ram_boot_loader_if.master  ramif,
  output logic               cpu_enable,
  output logic               busy,
  output logic               error
);

  // Checksum accumulate, wrapping modulo 2^DATALINES.
  function automatic logic [DATALINES-1:0] sum_wrap(
    input logic [DATALINES-1:0] a,
    input logic [DATALINES-1:0] b
  );
    return a + b;
  endfunction

  state_t               state_q, state_d;
  logic                 done_q, done_d;
  logic                 ver_q, ver_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;
  logic                 cpu_q, cpu_d;
  logic                 busy_q, busy_d;
  logic [ADLINES-1:0]   addr_p1, addr_d;
  logic [DATALINES-1:0] wdata_p1, wdata_d;
  logic                 vld_p1, vld_d;
  logic                 rd_p1, rd_d;
  logic [DATALINES-1:0] wsum_q, wsum_d;
  logic [DATALINES-1:0] rsum_q, rsum_d;

  logic                 seq_init, seq_clr, seq_inc;
  logic [ADLINES-1:0]   seq_addr, seq_addr_next;
  logic                 seq_last;
  logic                 accept;

  ram_addr_seq #(
    .ADLINES (ADLINES),
    .CNTW    (CNTW)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (seq_init),
    .base_in   (load_base),
    .count_in  (load_count),
    .clr       (seq_clr),
    .inc       (seq_inc),
    .addr      (seq_addr),
    .addr_next (seq_addr_next),
    .last      (seq_last)
  );

  assign accept = ramif.in_valid & rdy_q;

  // Next state and next registered outputs; everything defaults to idle bus.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    ver_d    = ver_q;
    err_d    = err_q;
    rdy_d    = 1'b0;
    cpu_d    = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    vld_d    = 1'b0;
    rd_d     = 1'b0;
    wsum_d   = wsum_q;
    rsum_d   = rsum_q;
    seq_init = 1'b0;
    seq_clr  = 1'b0;
    seq_inc  = 1'b0;

    if (halt) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAIL: begin
          if (load_start) begin
            seq_init = 1'b1;
            ver_d    = verify_en;
            err_d    = 1'b0;
            done_d   = 1'b0;
            wsum_d   = '0;
            rsum_d   = '0;
            if (load_count == '0) begin
              state_d = ST_RUN;
              cpu_d   = 1'b1;
            end else begin
              state_d = ST_LOAD;
              rdy_d   = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (done_q) begin
            // Last write cycle is on the bus now; leave LOAD at its close.
            done_d = 1'b0;
            if (ver_q) begin
              state_d = ST_VERIFY;
              addr_d  = seq_addr;
              rd_d    = 1'b1;
            end else begin
              state_d = ST_RUN;
              cpu_d   = 1'b1;
            end
          end else begin
            rdy_d = 1'b1;
            if (accept) begin
              addr_d  = seq_addr;
              wdata_d = ramif.in_data;
              vld_d   = 1'b1;
              wsum_d  = sum_wrap(wsum_q, ramif.in_data);
              if (seq_last) begin
                seq_clr = 1'b1;
                done_d  = 1'b1;
                rdy_d   = 1'b0;
              end else begin
                seq_inc = 1'b1;
              end
            end
          end
        end
        ST_VERIFY: begin
          // The read on the bus this cycle is closed out at this edge.
          rsum_d = sum_wrap(rsum_q, ramif.fromram);
          if (seq_last) begin
            state_d = ST_CHECK;
          end else begin
            seq_inc = 1'b1;
            addr_d  = seq_addr_next;
            rd_d    = 1'b1;
          end
        end
        ST_CHECK: begin
          if (rsum_q == wsum_q) begin
            state_d = ST_RUN;
            cpu_d   = 1'b1;
          end else begin
            state_d = ST_FAIL;
            err_d   = 1'b1;
          end
        end
        ST_RUN: begin
          cpu_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = is_busy_state(state_d);
  end

  // Control state and all registered outputs (stage p1 drives the RAM bus).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      ver_q    <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      cpu_q    <= 1'b0;
      busy_q   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      vld_p1   <= 1'b0;
      rd_p1    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      ver_q    <= ver_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      cpu_q    <= cpu_d;
      busy_q   <= busy_d;
      addr_p1  <= addr_d;
      wdata_p1 <= wdata_d;
      vld_p1   <= vld_d;
      rd_p1    <= rd_d;
    end
  end

  // Checksum accumulators; cleared by every accepted load_start before use.
  always_ff @(posedge clk) begin
    wsum_q <= wsum_d;
    rsum_q <= rsum_d;
  end

  assign ramif.in_ready   = rdy_q;
  assign ramif.addressbus = addr_p1;
  assign ramif.toram      = wdata_p1;
  assign ramif.write      = vld_p1;
  assign ramif.read       = rd_p1;
  assign cpu_enable       = cpu_q;
  assign busy             = busy_q;
  assign error            = err_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Bench for ram_boot_loader: RAM model, scoreboard of expected bus
// writes/reads fed by the stimulus, and a behavioural model of the load
// (modular addresses, last-write-wins image, wrapped checksums).
`timescale 1ns/1ps
module tb_ram_boot_loader;

  localparam int DL = 16;
  localparam int AL = 8;
  localparam int CW = AL + 1;

  typedef struct packed {
    logic [AL-1:0] a;
    logic [DL-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_start = 1'b0;
  logic [AL-1:0] load_base = '0;
  logic [CW-1:0] load_count = '0;
  logic          verify_en = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_enable, busy, error;

  logic          corrupt_en = 1'b0;
  logic [AL-1:0] corrupt_addr = '0;
  logic [DL-1:0] corrupt_val = '0;
  logic [DL-1:0] mem [0:255];

  int            nchk = 0;
  int            nerr = 0;
  int            cyc = 0;
  int            last_wr_cyc = 0;
  wr_t           exp_wr[$];
  logic [AL-1:0] exp_rd[$];
  logic [DL-1:0] wq[$];

  ram_boot_loader_if #(.DATALINES(DL), .ADLINES(AL)) bif ();

  ram_boot_loader #(.DATALINES(DL), .ADLINES(AL), .CNTW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .verify_en  (verify_en),
    .halt       (halt),
    .ramif      (bif),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .error      (error)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // RAM model: synchronous write, combinational read with optional fault.
  always @(posedge clk) if (bif.write) mem[bif.addressbus] <= bif.toram;
  always_comb bif.fromram = (corrupt_en && bif.addressbus == corrupt_addr)
                            ? corrupt_val : mem[bif.addressbus];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM strobe is popped from the scoreboard and compared.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bif.write) begin
          last_wr_cyc = cyc;
          if (exp_wr.size() == 0) chk("unexpected_write", 32'(bif.addressbus), 32'hFFFF_FFFF);
          else begin
            e = exp_wr.pop_front();
            chk("write_addr", 32'(bif.addressbus), 32'(e.a));
            chk("write_data", 32'(bif.toram), 32'(e.d));
          end
        end
        if (bif.read) begin
          if (exp_rd.size() == 0) chk("unexpected_read", 32'(bif.addressbus), 32'hFFFF_FFFF);
          else chk("read_addr", 32'(bif.addressbus), 32'(exp_rd.pop_front()));
        end
        if (cpu_enable) chk("bus_released_in_run",
                            {bif.read, bif.write, 6'(0), bif.addressbus, bif.toram}, 32'h0);
      end
    end
  end

  task automatic go_idle();
    @(negedge clk); halt = 1'b1;
    @(posedge clk); #1;
    chk("halt_cpu_enable", 32'(cpu_enable), 0);
    chk("halt_busy", 32'(busy), 0);
    @(negedge clk); halt = 1'b0;
  endtask

  // One complete load of the words in wq; expectations come from the model.
  task automatic do_load(input logic [AL-1:0] base, input bit ver, input int gapmax,
                         input int gap_at, input int gap_len);
    int            n, ng, waitc;
    logic [DL-1:0] em [0:255];
    logic [DL-1:0] wsum, rsum, rb;
    logic [AL-1:0] a;
    bit            pass;
    n = wq.size();
    if (cpu_enable) go_idle();
    wsum = '0;
    rsum = '0;
    for (int i = 0; i < n; i++) begin
      a = base + AL'(i);
      em[a] = wq[i];
      wsum = wsum + wq[i];
      exp_wr.push_back({a, wq[i]});
    end
    if (ver) for (int i = 0; i < n; i++) begin
      a = base + AL'(i);
      exp_rd.push_back(a);
      rb = (corrupt_en && a == corrupt_addr) ? corrupt_val : em[a];
      rsum = rsum + rb;
    end
    pass = !ver || (wsum == rsum);

    @(negedge clk);
    load_start = 1'b1; load_base = base; load_count = CW'(n); verify_en = ver;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("error_cleared_by_start", 32'(error), 0);
    if (n == 0) begin
      chk("cnt0_cpu_enable", 32'(cpu_enable), 1);
      chk("cnt0_in_ready", 32'(bif.in_ready), 0);
      chk("cnt0_busy", 32'(busy), 0);
    end else begin
      chk("in_ready_after_start", 32'(bif.in_ready), 1);
      chk("busy_after_start", 32'(busy), 1);
    end

    for (int i = 0; i < n; i++) begin
      ng = (i == gap_at) ? gap_len : ((gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
      repeat (ng) begin @(negedge clk); bif.in_valid = 1'b0; end
      @(negedge clk); bif.in_valid = 1'b1; bif.in_data = wq[i];
      waitc = 0;
      while (!bif.in_ready && waitc < 50) begin @(negedge clk); waitc++; end
      if (!bif.in_ready) begin chk("in_ready_timeout", 0, 1); break; end
      @(posedge clk);
    end
    @(negedge clk); bif.in_valid = 1'b0;
    if (n > 0) begin
      chk("in_ready_drops_after_last", 32'(bif.in_ready), 0);
      waitc = 0;
      while (!(cpu_enable || error) && waitc < n + 40) begin @(negedge clk); waitc++; end
      chk("outcome_cpu_enable", 32'(cpu_enable), 32'(pass));
      chk("outcome_error", 32'(error), 32'(!pass));
      chk("outcome_latency", 32'(cyc - last_wr_cyc), ver ? 32'(n + 2) : 32'd1);
      if (!pass) begin
        @(negedge clk);
        chk("fail_cpu_stays_off", 32'(cpu_enable), 0);
        chk("fail_error_sticky", 32'(error), 1);
      end
    end
    chk("write_queue_drained", 32'(exp_wr.size()), 0);
    chk("read_queue_drained", 32'(exp_rd.size()), 0);
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit v;
    logic [AL-1:0] b;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", 32'(bif.in_ready), 0);
    chk("rst_addressbus", 32'(bif.addressbus), 0);
    chk("rst_toram", 32'(bif.toram), 0);
    chk("rst_read", 32'(bif.read), 0);
    chk("rst_write", 32'(bif.write), 0);
    chk("rst_cpu_enable", 32'(cpu_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    @(negedge clk); rst_n = 1'b1;

    // Two words at 16, no verify.
    wq = '{16'd5, 16'd2};
    do_load(8'd16, 1'b0, 0, -1, 0);

    // Three words at 1 with a two-cycle stream gap, verify on.
    wq = '{16'h0086, 16'h018E, 16'h0000};
    do_load(8'd1, 1'b1, 0, 1, 2);

    // Address wrap FE, FF, 00, 01.
    for (int i = 0; i < 4; i++) wq.push_back(DL'($urandom));
    do_load(8'hFE, 1'b1, 0, -1, 0);

    // Readback fault at address 17 forces a checksum failure.
    corrupt_en = 1'b1; corrupt_addr = 8'd17; corrupt_val = 16'd3;
    wq = '{16'd5, 16'd2};
    do_load(8'd16, 1'b1, 0, -1, 0);
    corrupt_en = 1'b0;
    // Restart from FAIL clears error and passes.
    wq = '{16'h1234, 16'hABCD};
    do_load(8'd16, 1'b1, 0, -1, 0);

    // Empty image goes straight to RUN.
    do_load(8'h33, 1'b1, 0, -1, 0);
    @(negedge clk);
    load_start = 1'b1; load_base = 8'h00; load_count = CW'(5);
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("run_ignores_start_in_ready", 32'(bif.in_ready), 0);
    chk("run_ignores_start_cpu", 32'(cpu_enable), 1);
    chk("run_ignores_start_busy", 32'(busy), 0);
    go_idle();

    // Asynchronous reset after one of four words.
    exp_wr.push_back({8'h40, 16'hBEEF});
    @(negedge clk);
    load_start = 1'b1; load_base = 8'h40; load_count = CW'(4); verify_en = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk); bif.in_valid = 1'b1; bif.in_data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk); bif.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bif.in_ready), 0);
    chk("midrst_addressbus", 32'(bif.addressbus), 0);
    chk("midrst_toram", 32'(bif.toram), 0);
    chk("midrst_strobes", {30'(0), bif.read, bif.write}, 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_strobes", {30'(0), bif.read, bif.write}, 0);
    end
    rst_n = 1'b1;
    chk("midrst_queue", 32'(exp_wr.size()), 0);

    // Image longer than the RAM: wrapped writes overwrite from base.
    for (int i = 0; i < 260; i++) wq.push_back(DL'($urandom));
    do_load(8'hF0, 1'b1, 0, -1, 0);

    // Randomised loads.
    for (int t = 0; t < 12; t++) begin
      n = int'($urandom_range(24, 1));
      v = 1'($urandom);
      b = AL'($urandom);
      for (int i = 0; i < n; i++) wq.push_back(DL'($urandom));
      if ($urandom_range(2, 0) == 0) begin
        corrupt_en = 1'b1;
        corrupt_addr = b + AL'($urandom_range(n - 1, 0));
        corrupt_val = DL'($urandom);
      end
      do_load(b, v, 2, -1, 0);
      corrupt_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
